// File: rtl/uart_rx_oversampled_if.sv
// uart_rx_oversampled_if: oversample tick, serial line and received-byte outputs of the UART receiver.
// parity_error exists only when UART_RX_PARITY_EN is defined.
interface uart_rx_oversampled_if #(parameter int DATA_BITS = 8);
    logic                 en_baud;
    logic                 rx;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_valid;
    logic                 frame_error;
    logic                 busy;
`ifdef UART_RX_PARITY_EN
    logic                 parity_error;
    modport master (output en_baud, rx, input data_out, data_valid, frame_error, busy, parity_error);
    modport slave  (input en_baud, rx, output data_out, data_valid, frame_error, busy, parity_error);
`else
    modport master (output en_baud, rx, input data_out, data_valid, frame_error, busy);
    modport slave  (input en_baud, rx, output data_out, data_valid, frame_error, busy);
`endif
endinterface

// File: rtl/uart_rx_oversampled.sv
// uart_rx_oversampled: oversampled 8N1 UART receiver with framing-error detect.
// Defining UART_RX_PARITY_EN adds an even-parity bit before the stop bit and a parity_error pulse.
module uart_rx_oversampled #(
    parameter int OVERSAMPLE = 16,
    parameter int DATA_BITS  = 8
) (
    input logic              clk,
    input logic              rst_n,
    uart_rx_oversampled_if.slave bus
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;
    state_t               state_q, state_d;
    logic [TW-1:0]        tick_q, tick_d;
    logic [BW-1:0]        bit_q, bit_d;
    logic [DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                 valid_q, valid_d, ferr_q, ferr_d;
    logic                 rx_meta_q, rx_s_q;
    logic                 armed_q, armed_d;
    logic                 par_ok;
`ifdef UART_RX_PARITY_EN
    logic                 par_q, par_d, perr_q, perr_d;
    assign par_ok = ~(^shift_q ^ par_q);
`else
    assign par_ok = 1'b1;
`endif
    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        ferr_d  = 1'b0;
        // re-arming after a framing error needs the line seen high on a tick
        armed_d = armed_q | (bus.en_baud & rx_s_q);
`ifdef UART_RX_PARITY_EN
        par_d   = par_q;
        perr_d  = 1'b0;
`endif
        if (bus.en_baud) begin
            case (state_q)
                IDLE: if (armed_q && !rx_s_q) begin
                    state_d = START;
                    tick_d  = '0;
                end
                START: if (tick_q == HALF) begin
                    tick_d  = '0;
                    bit_d   = '0;
                    state_d = rx_s_q ? IDLE : DATA;
                end else tick_d = tick_q + TW'(1);
                DATA: if (tick_q == LAST) begin
                    shift_d = {rx_s_q, shift_q[DATA_BITS-1:1]};
                    tick_d  = '0;
                    bit_d   = bit_q + BW'(1);
`ifdef UART_RX_PARITY_EN
                    if (bit_q == LAST_BIT) state_d = PARITY;
`else
                    if (bit_q == LAST_BIT) state_d = STOP;
`endif
                end else tick_d = tick_q + TW'(1);
`ifdef UART_RX_PARITY_EN
                PARITY: if (tick_q == LAST) begin
                    par_d   = rx_s_q;
                    tick_d  = '0;
                    state_d = STOP;
                end else tick_d = tick_q + TW'(1);
`endif
                STOP: if (tick_q == LAST) begin
                    tick_d  = '0;
                    state_d = IDLE;
                    if (!rx_s_q) begin
                        ferr_d  = 1'b1;
                        armed_d = 1'b0;
                    end else if (par_ok) begin
                        valid_d = 1'b1;
                        data_d  = shift_q;
                    end
`ifdef UART_RX_PARITY_EN
                    else perr_d = 1'b1;
`endif
                end else tick_d = tick_q + TW'(1);
                default: state_d = IDLE;
            endcase
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tick_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            ferr_q    <= 1'b0;
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            armed_q   <= 1'b1;
`ifdef UART_RX_PARITY_EN
            par_q     <= 1'b0;
            perr_q    <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            tick_q    <= tick_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            ferr_q    <= ferr_d;
            rx_meta_q <= bus.rx;
            rx_s_q    <= rx_meta_q;
            armed_q   <= armed_d;
`ifdef UART_RX_PARITY_EN
            par_q     <= par_d;
            perr_q    <= perr_d;
`endif
        end
    end
    assign bus.data_out    = data_q;
    assign bus.data_valid  = valid_q;
    assign bus.frame_error = ferr_q;
    assign bus.busy        = (state_q != IDLE);
`ifdef UART_RX_PARITY_EN
    assign bus.parity_error = perr_q;
`endif
endmodule

// File: tb/tb_uart_rx_oversampled.sv
// tb_uart_rx_oversampled: directed frames at OVERSAMPLE=16, one tick every 4 clk (64 clk per bit).
module tb_uart_rx_oversampled;
    localparam int OS = 16;
    localparam int BT = 64;
`ifdef UART_RX_PARITY_EN
    localparam int FB = 11;
`else
    localparam int FB = 10;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_rx_oversampled_if #(.DATA_BITS(8)) bus ();
    uart_rx_oversampled #(.OVERSAMPLE(OS), .DATA_BITS(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
    always #5 clk = ~clk;
    int checks = 0, failures = 0;
    int vcnt = 0, fcnt = 0, pcnt = 0, both = 0, cyc = 0, last_t = 0, prev_t = 0;
    logic [7:0] last_d = 8'h00, prev_d = 8'h00;
    int v0, f0, p0, rise, fall;
    initial begin
        bus.en_baud = 1'b0;
        forever begin
            repeat (3) @(negedge clk);
            bus.en_baud = 1'b1;
            @(negedge clk);
            bus.en_baud = 1'b0;
        end
    end
    always @(negedge clk) begin
        cyc++;
        if (bus.data_valid) begin
            prev_d = last_d;
            prev_t = last_t;
            last_d = bus.data_out;
            last_t = cyc;
            vcnt++;
        end
        if (bus.frame_error) fcnt++;
        if (bus.data_valid && bus.frame_error) both++;
`ifdef UART_RX_PARITY_EN
        if (bus.parity_error) pcnt++;
        if (bus.parity_error && (bus.data_valid || bus.frame_error)) both++;
`endif
    end
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask
    task automatic send_bit(input logic v);
        bus.rx = v;
        repeat (BT) @(negedge clk);
    endtask
    task automatic send_frame(input logic [7:0] d, input logic stop_v);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
`ifdef UART_RX_PARITY_EN
        send_bit(^d);
`endif
        send_bit(stop_v);
    endtask
`ifdef UART_RX_PARITY_EN
    task automatic send_par_frame(input logic [7:0] d, input logic p);
        send_bit(1'b0);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        send_bit(p);
        send_bit(1'b1);
    endtask
`endif
    initial begin
        bus.rx = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", bus.data_out, 8'h00);
        check("rst_valid", bus.data_valid, 1'b0);
        check("rst_ferr", bus.frame_error, 1'b0);
        check("rst_busy", bus.busy, 1'b0);
        rst_n = 1'b1;
        repeat (BT) @(negedge clk);
        v0 = vcnt; f0 = fcnt;
        send_frame(8'hA5, 1'b1);
        send_bit(1'b1);
        check("a5_valid_cnt", vcnt - v0, 1);
        check("a5_data", bus.data_out, 8'hA5);
        check("a5_ferr_cnt", fcnt - f0, 0);
        check("a5_busy_idle", bus.busy, 1'b0);
        v0 = vcnt; f0 = fcnt; rise = -1; fall = -1;
        bus.rx = 1'b0;
        for (int k = 1; k <= 80; k++) begin
            @(negedge clk);
            if (k == 12) bus.rx = 1'b1;
            if (rise < 0 && bus.busy) rise = k;
            if (rise >= 0 && fall < 0 && !bus.busy) fall = k;
        end
        check("glitch_busy_rose", rise > 0, 1'b1);
        check("glitch_busy_len", fall - rise, 32);
        check("glitch_valid_cnt", vcnt - v0, 0);
        check("glitch_ferr_cnt", fcnt - f0, 0);
        v0 = vcnt; f0 = fcnt;
        send_frame(8'h3C, 1'b0);
        bus.rx = 1'b0;
        repeat (2 * FB * BT) @(negedge clk);
        check("break_ferr_cnt", fcnt - f0, 1);
        check("break_valid_cnt", vcnt - v0, 0);
        check("break_data_kept", bus.data_out, 8'hA5);
        send_bit(1'b1);
        send_bit(1'b1);
        send_frame(8'h55, 1'b1);
        send_bit(1'b1);
        check("after_break_valid", vcnt - v0, 1);
        check("after_break_data", bus.data_out, 8'h55);
        check("after_break_ferr", fcnt - f0, 1);
        v0 = vcnt;
        send_frame(8'h00, 1'b1);
        send_frame(8'hFF, 1'b1);
        send_bit(1'b1);
        check("b2b_valid_cnt", vcnt - v0, 2);
        check("b2b_first", prev_d, 8'h00);
        check("b2b_second", last_d, 8'hFF);
        check("b2b_spacing", last_t - prev_t, FB * BT);
        v0 = vcnt; f0 = fcnt;
        send_bit(1'b0);
        for (int i = 0; i < 4; i++) send_bit(i == 0);
        bus.rx = 1'b0;
        repeat (BT / 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("abort_busy", bus.busy, 1'b0);
        check("abort_data", bus.data_out, 8'h00);
        repeat (8) @(negedge clk);
        bus.rx = 1'b1;
        rst_n = 1'b1;
        repeat (2 * BT) @(negedge clk);
        check("abort_no_pulse", (vcnt - v0) + (fcnt - f0), 0);
        send_frame(8'h81, 1'b1);
        send_bit(1'b1);
        check("resend_valid_cnt", vcnt - v0, 1);
        check("resend_data", bus.data_out, 8'h81);
`ifdef UART_RX_PARITY_EN
        v0 = vcnt; p0 = pcnt;
        send_par_frame(8'h07, 1'b0);
        send_bit(1'b1);
        check("par_bad_perr", pcnt - p0, 1);
        check("par_bad_valid", vcnt - v0, 0);
        check("par_bad_data", bus.data_out, 8'h81);
        send_par_frame(8'h07, 1'b1);
        send_bit(1'b1);
        check("par_good_valid", vcnt - v0, 1);
        check("par_good_data", bus.data_out, 8'h07);
        check("par_good_perr", pcnt - p0, 1);
`else
        p0 = pcnt;
        check("no_parity_pulses", pcnt - p0, 0);
`endif
        check("no_overlap", both, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
